// File: rtl/spi_req_sched_pkg.sv
// Shared constants for the SPI request scheduler: SPI core register map,
// CTRL register bit positions and the scheduler FSM encoding.
package spi_req_sched_pkg;

    localparam logic [4:0] ADR_TX0    = 5'h00;
    localparam logic [4:0] ADR_CTRL   = 5'h10;
    localparam logic [4:0] ADR_DIVIDE = 5'h14;
    localparam logic [4:0] ADR_SS     = 5'h18;

    localparam int CTRL_GO     = 8;
    localparam int CTRL_RX_NEG = 9;
    localparam int CTRL_TX_NEG = 10;
    localparam int CTRL_LSB    = 11;
    localparam int CTRL_IE     = 12;
    localparam int CTRL_ASS    = 13;

    typedef enum logic [2:0] {
        INIT_DIV = 3'd0,
        IDLE     = 3'd1,
        WR_SS    = 3'd2,
        WR_TX    = 3'd3,
        WR_CTRL  = 3'd4,
        WAIT_INT = 3'd5,
        RD_RX    = 3'd6,
        RESP     = 3'd7
    } state_e;

    // CTRL word that starts a transfer; mode is {lsb, tx_negedge, rx_negedge}.
    // Interrupts and automatic slave select are always on.
    function automatic logic [31:0] ctrl_word(input logic [6:0] len, input logic [2:0] mode);
        logic [31:0] w;
        w              = '0;
        w[6:0]         = len;
        w[CTRL_GO]     = 1'b1;
        w[CTRL_RX_NEG] = mode[0];
        w[CTRL_TX_NEG] = mode[1];
        w[CTRL_LSB]    = mode[2];
        w[CTRL_IE]     = 1'b1;
        w[CTRL_ASS]    = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/spi_rr_arb.sv
// NREQ-way round-robin arbiter. Grant is combinational and one-hot; the
// pointer remembers the last accepted port so the search starts after it.
module spi_rr_arb #(
    parameter int NREQ = 2
) (
    input  logic            wb_clk_in,
    input  logic            wb_rst_in,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] grant
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;

    // Scan ports ptr+1, ptr+2, ... (wrapping); first active requester wins.
    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[PW'(idx)]) begin
                grant[PW'(idx)] = 1'b1;
                grant_idx       = PW'(idx);
                found           = 1'b1;
            end
        end
    end

    // Pointer starts on the last port so port 0 wins first after reset.
    always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
        if (wb_rst_in)
            ptr <= PW'(NREQ - 1);
        else if (accept && |req)
            ptr <= grant_idx;
    end

endmodule

// File: rtl/spi_req_sched.sv
// Multi-port scheduler that turns per-port SPI transfer requests into a
// Wishbone register sequence on an SPI master core (SS, TX0, CTRL, wait
// for interrupt, read RX0) and returns the received word to the requester.
module spi_req_sched
    import spi_req_sched_pkg::*;
#(
    parameter int          NREQ    = 2,
    parameter logic [15:0] DIVIDER = 16'd4,
    parameter int          TMO_CYC = 65535
) (
    input  logic              wb_clk_in,
    input  logic              wb_rst_in,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_ss,
    input  logic [NREQ*7-1:0] req_len,
    input  logic [NREQ*3-1:0] req_mode,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              m_cyc,
    output logic              m_stb,
    output logic              m_we,
    output logic [4:0]        m_adr,
    output logic [3:0]        m_sel,
    output logic [31:0]       m_dat_o,
    input  logic [31:0]       m_dat_i,
    input  logic              m_ack,
    input  logic              spi_int
);
    localparam int TW = $clog2(TMO_CYC + 1);

    state_e          state;
    state_e          bus_next;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] gnt_q;
    logic            accept;
    logic [7:0]      ss_q,   sel_ss;
    logic [6:0]      len_q,  sel_len;
    logic [2:0]      mode_q, sel_mode;
    logic [31:0]     tx_q,   sel_data;
    logic [TW-1:0]   tmo_cnt;
    logic [4:0]      bus_adr;
    logic [3:0]      bus_sel;
    logic            bus_we;
    logic [31:0]     bus_dat;

    assign accept    = (state == IDLE) && (|req_valid);
    // Ready is combinational so the requester sees it in the grant cycle itself.
    assign req_ready = (state == IDLE) ? gnt : '0;

    spi_rr_arb #(.NREQ(NREQ)) u_arb (
        .wb_clk_in (wb_clk_in),
        .wb_rst_in (wb_rst_in),
        .req       (req_valid),
        .accept    (accept),
        .grant     (gnt)
    );

    // Pick the granted port's request fields.
    always_comb begin
        sel_ss   = '0;
        sel_len  = '0;
        sel_mode = '0;
        sel_data = '0;
        for (int p = 0; p < NREQ; p++) begin
            if (gnt[p]) begin
                sel_ss   = req_ss[p*8 +: 8];
                sel_len  = req_len[p*7 +: 7];
                sel_mode = req_mode[p*3 +: 3];
                sel_data = req_data[p*32 +: 32];
            end
        end
    end

    // Bus access parameters and follow-on state for each bus-owning state.
    always_comb begin
        bus_adr  = ADR_TX0;
        bus_sel  = 4'b1111;
        bus_we   = 1'b1;
        bus_dat  = '0;
        bus_next = IDLE;
        case (state)
            INIT_DIV: begin
                bus_adr  = ADR_DIVIDE;
                bus_sel  = 4'b0011;
                bus_dat  = {16'h0000, DIVIDER};
                bus_next = IDLE;
            end
            WR_SS: begin
                bus_adr  = ADR_SS;
                bus_sel  = 4'b0001;
                bus_dat  = {24'h000000, ss_q};
                bus_next = WR_TX;
            end
            WR_TX: begin
                bus_dat  = tx_q;
                bus_next = WR_CTRL;
            end
            WR_CTRL: begin
                bus_adr  = ADR_CTRL;
                bus_sel  = 4'b0011;
                bus_dat  = ctrl_word(len_q, mode_q);
                bus_next = WAIT_INT;
            end
            RD_RX: begin
                bus_we   = 1'b0;
                bus_next = RESP;
            end
            default: ;
        endcase
    end

    // Main FSM: grant, run the Wishbone sequence, wait for the core, respond.
    // A bus access raises the strobes for one state visit and drops them on
    // ack, which leaves one idle bus cycle before the next access.
    always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
        if (wb_rst_in) begin
            state     <= INIT_DIV;
            m_cyc     <= 1'b0;
            m_stb     <= 1'b0;
            m_we      <= 1'b0;
            m_adr     <= '0;
            m_sel     <= '0;
            m_dat_o   <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            tmo_cnt   <= '0;
            gnt_q     <= '0;
            ss_q      <= '0;
            len_q     <= '0;
            mode_q    <= '0;
            tx_q      <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt_q  <= gnt;
                        ss_q   <= sel_ss;
                        len_q  <= sel_len;
                        mode_q <= sel_mode;
                        tx_q   <= sel_data;
                        state  <= WR_SS;
                    end
                end
                WAIT_INT: begin
                    if (spi_int) begin
                        state <= RD_RX;
                    end else if (tmo_cnt == '0) begin
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_valid <= gnt_q;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: begin
                    if (!m_cyc) begin
                        m_cyc   <= 1'b1;
                        m_stb   <= 1'b1;
                        m_we    <= bus_we;
                        m_adr   <= bus_adr;
                        m_sel   <= bus_sel;
                        m_dat_o <= bus_dat;
                    end else if (m_ack) begin
                        m_cyc   <= 1'b0;
                        m_stb   <= 1'b0;
                        m_we    <= 1'b0;
                        m_adr   <= '0;
                        m_sel   <= '0;
                        m_dat_o <= '0;
                        state   <= bus_next;
                        if (state == WR_CTRL)
                            tmo_cnt <= TW'(TMO_CYC);
                        if (state == RD_RX) begin
                            rsp_data  <= m_dat_i;
                            rsp_err   <= 1'b0;
                            rsp_valid <= gnt_q;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_req_sched.sv
// Directed bench for spi_req_sched with a Wishbone SPI-core model that
// acks after a programmable delay and raises spi_int after a CTRL GO write.
module tb_spi_req_sched;
    localparam int NREQ = 2;

    logic               wb_clk_in = 1'b0;
    logic               wb_rst_in = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*8-1:0]  req_ss    = '0;
    logic [NREQ*7-1:0]  req_len   = '0;
    logic [NREQ*3-1:0]  req_mode  = '0;
    logic [NREQ*32-1:0] req_data  = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_data;
    logic               rsp_err;
    logic               m_cyc, m_stb, m_we;
    logic [4:0]         m_adr;
    logic [3:0]         m_sel;
    logic [31:0]        m_dat_o;
    logic [31:0]        m_dat_i;
    logic               m_ack   = 1'b0;
    logic               spi_int = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    // core model state
    int          ack_dly = 0;
    int          wcnt = 0;
    int          unstable_cnt = 0;
    int          b2b_cnt = 0;
    int          int_cnt = 0;
    logic        int_en = 1'b1;
    logic [31:0] rx_word = 32'h0;
    logic [4:0]  h_adr;
    logic [3:0]  h_sel;
    logic        h_we;
    logic [31:0] h_dat;

    logic [4:0]  log_adr[$];
    logic [3:0]  log_sel[$];
    logic        log_we[$];
    logic [31:0] log_dat[$];
    int          log_cyc[$];
    int          log_dur[$];
    int          rsp_port[$];
    logic [31:0] rsp_dat_q[$];
    logic        rsp_err_q[$];
    int          rsp_cyc[$];
    int          gnt_q[$];

    assign m_dat_i = rx_word;

    spi_req_sched #(.NREQ(NREQ), .DIVIDER(16'd4), .TMO_CYC(100)) dut (
        .wb_clk_in (wb_clk_in),
        .wb_rst_in (wb_rst_in),
        .req_valid (req_valid),
        .req_ss    (req_ss),
        .req_len   (req_len),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .m_cyc     (m_cyc),
        .m_stb     (m_stb),
        .m_we      (m_we),
        .m_adr     (m_adr),
        .m_sel     (m_sel),
        .m_dat_o   (m_dat_o),
        .m_dat_i   (m_dat_i),
        .m_ack     (m_ack),
        .spi_int   (spi_int)
    );

    always #5 wb_clk_in = ~wb_clk_in;
    always @(posedge wb_clk_in) cyc_n++;

    // SPI core / Wishbone slave model, driven on the falling edge
    always @(negedge wb_clk_in) begin
        if (int_cnt > 0) begin
            int_cnt--;
            if (int_cnt == 0) spi_int = 1'b1;
        end
        if (m_ack) begin
            m_ack = 1'b0;
            if (m_cyc) b2b_cnt++;
        end else if (m_cyc && m_stb) begin
            if (wcnt == 0) begin
                h_adr = m_adr; h_sel = m_sel; h_we = m_we; h_dat = m_dat_o;
            end else if (m_adr !== h_adr || m_sel !== h_sel || m_we !== h_we || m_dat_o !== h_dat) begin
                unstable_cnt++;
            end
            if (wcnt >= ack_dly) begin
                m_ack = 1'b1;
                log_adr.push_back(m_adr);
                log_sel.push_back(m_sel);
                log_we.push_back(m_we);
                log_dat.push_back(m_dat_o);
                log_cyc.push_back(cyc_n);
                log_dur.push_back(wcnt + 1);
                if (m_we && m_adr == 5'h10 && m_dat_o[8] && int_en) int_cnt = 3;
                if (!m_we && m_adr == 5'h00) spi_int = 1'b0;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // response and grant recorder
    always @(negedge wb_clk_in) begin
        for (int p = 0; p < NREQ; p++) begin
            if (rsp_valid[p]) begin
                rsp_port.push_back(p);
                rsp_dat_q.push_back(rsp_data);
                rsp_err_q.push_back(rsp_err);
                rsp_cyc.push_back(cyc_n);
            end
            if (req_ready[p]) gnt_q.push_back(p);
        end
    end

    task automatic clear_logs();
        log_adr.delete(); log_sel.delete(); log_we.delete(); log_dat.delete();
        log_cyc.delete(); log_dur.delete();
        rsp_port.delete(); rsp_dat_q.delete(); rsp_err_q.delete(); rsp_cyc.delete();
        gnt_q.delete();
    endtask

    task automatic set_port(input int p, input logic [7:0] ss, input logic [6:0] len,
                            input logic [2:0] mode, input logic [31:0] dat);
        req_ss[p*8 +: 8]    = ss;
        req_len[p*7 +: 7]   = len;
        req_mode[p*3 +: 3]  = mode;
        req_data[p*32 +: 32] = dat;
    endtask

    task automatic test_reset();
        wb_rst_in = 1'b1;
        repeat (3) @(negedge wb_clk_in);
        total++;
        if (m_cyc !== 1'b0 || m_stb !== 1'b0 || m_we !== 1'b0 || m_adr !== 5'h0 || m_sel !== 4'h0)
            begin bad++; $display("FAIL reset_bus: cyc=%b stb=%b we=%b adr=%h sel=%h want all 0", m_cyc, m_stb, m_we, m_adr, m_sel); end
        total++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_data !== 32'h0)
            begin bad++; $display("FAIL reset_rsp: ready=%b rsp_valid=%b err=%b data=%h want 0", req_ready, rsp_valid, rsp_err, rsp_data); end
        clear_logs();
        @(posedge wb_clk_in); #1 wb_rst_in = 1'b0;
        for (int i = 0; i < 20 && log_adr.size() == 0; i++) @(negedge wb_clk_in);
        total++;
        if (log_adr.size() == 0) begin bad++; $display("FAIL reset_div: no bus access after reset"); end
        else if (log_adr[0] !== 5'h14 || log_we[0] !== 1'b1 || log_sel[0] !== 4'h3 || log_dat[0] !== 32'h4)
            begin bad++; $display("FAIL reset_div: adr=%h we=%b sel=%h dat=%h want 14 1 3 00000004", log_adr[0], log_we[0], log_sel[0], log_dat[0]); end
        repeat (20) @(negedge wb_clk_in);
        total++;
        if (log_adr.size() != 1 || m_cyc !== 1'b0)
            begin bad++; $display("FAIL reset_quiet: accesses=%0d cyc=%b want 1 0", log_adr.size(), m_cyc); end
    endtask

    task automatic test_single();
        logic [4:0]  e_adr[4] = '{5'h18, 5'h00, 5'h10, 5'h00};
        logic        e_we[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  e_sel[4] = '{4'h1, 4'hF, 4'h3, 4'hF};
        logic [31:0] e_dat[4] = '{32'h01, 32'hA5A51234, 32'h3120, 32'h0};
        clear_logs();
        rx_word = 32'hDEADBEEF;
        @(posedge wb_clk_in); #1;
        set_port(0, 8'h01, 7'd32, 3'b000, 32'hA5A51234);
        req_valid = 2'b01;
        for (int i = 0; i < 20 && req_ready[0] !== 1'b1; i++) @(negedge wb_clk_in);
        @(posedge wb_clk_in); #1 req_valid = 2'b00;
        for (int i = 0; i < 300 && rsp_port.size() == 0; i++) @(negedge wb_clk_in);
        repeat (5) @(negedge wb_clk_in);
        total++;
        if (gnt_q.size() != 1 || gnt_q[0] != 0) begin bad++; $display("FAIL single_grant: grants=%0d want one on port 0", gnt_q.size()); end
        total++;
        if (log_adr.size() != 4) begin bad++; $display("FAIL single_nacc: got %0d accesses want 4", log_adr.size()); end
        for (int i = 0; i < 4 && i < log_adr.size(); i++) begin
            total++;
            if (log_adr[i] !== e_adr[i] || log_we[i] !== e_we[i] || log_sel[i] !== e_sel[i] || (e_we[i] && log_dat[i] !== e_dat[i]))
                begin bad++; $display("FAIL single_acc%0d: adr=%h we=%b sel=%h dat=%h want %h %b %h %h", i, log_adr[i], log_we[i], log_sel[i], log_dat[i], e_adr[i], e_we[i], e_sel[i], e_dat[i]); end
        end
        total++;
        if (rsp_port.size() != 1) begin bad++; $display("FAIL single_rsp_cnt: got %0d rsp_valid cycles want 1", rsp_port.size()); end
        else if (rsp_port[0] != 0 || rsp_dat_q[0] !== 32'hDEADBEEF || rsp_err_q[0] !== 1'b0)
            begin bad++; $display("FAIL single_rsp: port=%0d data=%h err=%b want 0 deadbeef 0", rsp_port[0], rsp_dat_q[0], rsp_err_q[0]); end
        total++;
        if (rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_hold: rsp_data=%h want deadbeef", rsp_data); end
    endtask

    task automatic test_timeout();
        clear_logs();
        int_en = 1'b0;
        @(posedge wb_clk_in); #1;
        set_port(1, 8'h02, 7'd32, 3'b000, 32'h00000055);
        req_valid = 2'b10;
        for (int i = 0; i < 20 && req_ready[1] !== 1'b1; i++) @(negedge wb_clk_in);
        @(posedge wb_clk_in); #1 req_valid = 2'b00;
        for (int i = 0; i < 400 && rsp_port.size() == 0; i++) @(negedge wb_clk_in);
        repeat (5) @(negedge wb_clk_in);
        total++;
        if (rsp_port.size() != 1) begin bad++; $display("FAIL tmo_rsp_cnt: got %0d want 1", rsp_port.size()); end
        else if (rsp_port[0] != 1 || rsp_err_q[0] !== 1'b1 || rsp_dat_q[0] !== 32'h0)
            begin bad++; $display("FAIL tmo_rsp: port=%0d err=%b data=%h want 1 1 00000000", rsp_port[0], rsp_err_q[0], rsp_dat_q[0]); end
        total++;
        if (log_adr.size() != 3 || log_adr[2] !== 5'h10)
            begin bad++; $display("FAIL tmo_noread: accesses=%0d want 3 ending at CTRL", log_adr.size()); end
        total++;
        if (rsp_cyc.size() == 0 || log_cyc.size() < 3 || rsp_cyc[0] - log_cyc[2] != 102)
            begin bad++; $display("FAIL tmo_time: cycles from CTRL ack to rsp=%0d want 102", (rsp_cyc.size() > 0 && log_cyc.size() > 2) ? rsp_cyc[0] - log_cyc[2] : -1); end
        int_en = 1'b1;
    endtask

    task automatic test_round_robin();
        int e_gnt[4] = '{0, 1, 0, 1};
        clear_logs();
        rx_word = 32'h0BADF00D;
        @(posedge wb_clk_in); #1;
        set_port(0, 8'h01, 7'd0,  3'b000, 32'h11111111);
        set_port(1, 8'h02, 7'd16, 3'b111, 32'h22222222);
        req_valid = 2'b11;
        for (int i = 0; i < 2000 && gnt_q.size() < 4; i++) @(negedge wb_clk_in);
        @(posedge wb_clk_in); #1 req_valid = 2'b00;
        for (int i = 0; i < 2000 && rsp_port.size() < 4; i++) @(negedge wb_clk_in);
        repeat (10) @(negedge wb_clk_in);
        total++;
        if (gnt_q.size() != 4 || rsp_port.size() != 4)
            begin bad++; $display("FAIL rr_count: grants=%0d rsps=%0d want 4 4", gnt_q.size(), rsp_port.size()); end
        for (int i = 0; i < 4 && i < gnt_q.size() && i < rsp_port.size(); i++) begin
            total++;
            if (gnt_q[i] != e_gnt[i] || rsp_port[i] != e_gnt[i] || rsp_dat_q[i] !== 32'h0BADF00D || rsp_err_q[i] !== 1'b0)
                begin bad++; $display("FAIL rr_xfer%0d: grant=%0d rsp_port=%0d data=%h err=%b want %0d %0d 0badf00d 0", i, gnt_q[i], rsp_port[i], rsp_dat_q[i], rsp_err_q[i], e_gnt[i], e_gnt[i]); end
        end
        total++;
        if (log_dat.size() < 8 || log_dat[2] !== 32'h3100 || log_dat[4] !== 32'h02 || log_dat[6] !== 32'h3F10)
            begin bad++; $display("FAIL rr_ctrl: ctrl0=%h ss1=%h ctrl1=%h want 00003100 00000002 00003f10",
                log_dat.size() > 2 ? log_dat[2] : 32'hx, log_dat.size() > 4 ? log_dat[4] : 32'hx, log_dat.size() > 6 ? log_dat[6] : 32'hx); end
    endtask

    task automatic test_ack_delay();
        logic [4:0]  e_adr[4] = '{5'h18, 5'h00, 5'h10, 5'h00};
        logic [31:0] e_dat[4] = '{32'h01, 32'hA5A51234, 32'h3120, 32'h0};
        clear_logs();
        ack_dly = 3; unstable_cnt = 0; b2b_cnt = 0;
        rx_word = 32'hDEADBEEF;
        @(posedge wb_clk_in); #1;
        set_port(0, 8'h01, 7'd32, 3'b000, 32'hA5A51234);
        req_valid = 2'b01;
        for (int i = 0; i < 20 && req_ready[0] !== 1'b1; i++) @(negedge wb_clk_in);
        @(posedge wb_clk_in); #1 req_valid = 2'b00;
        for (int i = 0; i < 300 && rsp_port.size() == 0; i++) @(negedge wb_clk_in);
        repeat (5) @(negedge wb_clk_in);
        total++;
        if (unstable_cnt != 0 || b2b_cnt != 0)
            begin bad++; $display("FAIL dly_stable: unstable=%0d back_to_back=%0d want 0 0", unstable_cnt, b2b_cnt); end
        total++;
        if (log_adr.size() != 4) begin bad++; $display("FAIL dly_nacc: got %0d accesses want 4", log_adr.size()); end
        for (int i = 0; i < 4 && i < log_adr.size(); i++) begin
            total++;
            if (log_adr[i] !== e_adr[i] || log_dur[i] != 4 || (i < 3 && log_dat[i] !== e_dat[i]))
                begin bad++; $display("FAIL dly_acc%0d: adr=%h dur=%0d dat=%h want %h 4 %h", i, log_adr[i], log_dur[i], log_dat[i], e_adr[i], e_dat[i]); end
        end
        total++;
        if (rsp_port.size() != 1) begin bad++; $display("FAIL dly_rsp_cnt: got %0d want 1", rsp_port.size()); end
        else if (rsp_port[0] != 0 || rsp_dat_q[0] !== 32'hDEADBEEF || rsp_err_q[0] !== 1'b0)
            begin bad++; $display("FAIL dly_rsp: port=%0d data=%h err=%b want 0 deadbeef 0", rsp_port[0], rsp_dat_q[0], rsp_err_q[0]); end
    endtask

    task automatic test_reset_mid();
        logic hit;
        clear_logs();
        ack_dly = 3;
        @(posedge wb_clk_in); #1;
        set_port(0, 8'h04, 7'd8, 3'b000, 32'h12345678);
        req_valid = 2'b01;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge wb_clk_in);
            hit = (m_cyc === 1'b1 && m_we === 1'b1 && m_adr === 5'h00);
        end
        total++;
        if (!hit) begin bad++; $display("FAIL rstmid_reach: TX write never seen"); end
        #2 wb_rst_in = 1'b1;
        #1;
        total++;
        if (m_cyc !== 1'b0 || m_stb !== 1'b0) begin bad++; $display("FAIL rstmid_abort: cyc=%b stb=%b want 0 0", m_cyc, m_stb); end
        req_valid = 2'b00;
        clear_logs();
        repeat (2) @(posedge wb_clk_in);
        #1 wb_rst_in = 1'b0;
        ack_dly = 0;
        for (int i = 0; i < 20 && log_adr.size() == 0; i++) @(negedge wb_clk_in);
        repeat (30) @(negedge wb_clk_in);
        total++;
        if (log_adr.size() != 1 || log_adr[0] !== 5'h14 || log_dat[0] !== 32'h4)
            begin bad++; $display("FAIL rstmid_div: accesses=%0d first adr=%h dat=%h want 1 14 00000004",
                log_adr.size(), log_adr.size() > 0 ? log_adr[0] : 5'hx, log_dat.size() > 0 ? log_dat[0] : 32'hx); end
        total++;
        if (rsp_port.size() != 0) begin bad++; $display("FAIL rstmid_norsp: got %0d responses want 0", rsp_port.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_round_robin();
        test_ack_delay();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
